paddle_emu: RTL
===============

# paddle_emu

Per-player paddle emulation stage feeding the AY-3-8500 core's `pinLPin`/`pinRPin` inputs. Converts one player's control source into a per-frame delay: digital up/down with saturation and hold acceleration, analog stick axis, or paddle. The delay is loaded at each vertical sync and counted down on horizontal syncs. `pin_out` rises after the selected number of lines, which is how the chip reads bat position. Instantiated once per player in the top level; all inputs are synchronous to `clk_sys`.

## Interface
- `POS_INIT`, 128: digital position after reset (0..255).
- `SPEED_SLOW`, 5: digital step per frame when `fast`=0 (1..31).
- `SPEED_FAST`, 8: digital step per frame when `fast`=1 (1..31).
- `ACCEL_FRAMES`, 16: consecutive held frames before the step doubles; 0 disables acceleration.

- `clk_sys` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `hs` in 1: active-high horizontal sync.
- `vs` in 1: active-high vertical sync.
- `mode` in 2: 0 digital, 1 analog Y, 2 analog X, 3 paddle.
- `invert` in 1: XOR the loaded value with 8'hFF.
- `fast` in 1: selects `SPEED_FAST`.
- `btn_up`, `btn_down` in 1: digital controls, already ORed from keyboard and joystick.
- `analog` in 16: [15:8] Y, [7:0] X, each two's complement.
- `paddle` in 8: unsigned paddle value.
- `pos` out 8: current digital position.
- `pin_out` out 1: high when the countdown is 0.

## Operation
- Internal `hs_d` and `vs_d` registers; reset value 0.
  - A frame event is `vs & ~vs_d`.
  - A line event is `hs & ~hs_d`.
- Registers: `pos` 8b, `cap` 8b, `held` 5b (saturates at 31), `dir` state.
- `dir` state machine, evaluated on frame events in digital mode only:
  - States: IDLE, UP, DOWN.
  - `btn_up` only → UP.
  - `btn_down` only → DOWN.
  - Neither, or both → IDLE.
  - Entering a different state clears `held` to 0. Staying in UP or DOWN increments `held`, saturating.
- Step computation:
  - base = `fast` ? `SPEED_FAST` : `SPEED_SLOW`.
  - step = base<<1 when `ACCEL_FRAMES`≠0 and `held` ≥ `ACCEL_FRAMES`; otherwise step = base.
  - Use the `held` value from before this frame's update.
  - Arithmetic is 10-bit signed.
- Position update on a frame event in digital mode:
  - UP: `pos` ← max(`pos`−step, 0).
  - DOWN: `pos` ← min(`pos`+step, 255).
  - IDLE: `pos` unchanged.
- Load on a frame event; the loaded value is then XORed with {8{`invert`}} into `cap`:
  - Digital: `pos` before this frame's update (one-frame lag).
  - Analog Y: {~analog[15], analog[14:8]}.
  - Analog X: {~analog[7], analog[6:0]}.
  - Paddle: `paddle`.
- Non-digital modes: `pos` is held and `dir` is forced to IDLE with `held`=0.
- Line event without a frame event: if `cap`≠0 then `cap` ← `cap`−1.
- A frame event has priority over a simultaneous line event; the load wins and no decrement occurs.
- `pin_out` = (`cap`==0), combinational from the register.
- Reset values:
  - `pos`=`POS_INIT`, `cap`=0, `held`=0, `dir`=IDLE.
  - Therefore `pin_out`=1.
- `mode`, `fast`, and `invert` changes take effect only at the next frame event.

## Timing
- The `cap` load occurs on the clock edge where `vs`=1 and `vs_d`=0, i.e. the first `clk_sys` edge sampling `vs` high.
- `pin_out` reflects the loaded value in the following cycle.
- With a loaded value N>0, `pin_out` goes high in the cycle after the Nth line event.
- Loaded value 0: `pin_out` stays 1 through the frame.
- `cap` holds at 0; there is no wrap-around.
- `pos` updates in the same cycle as the `cap` load.
- Deasserting reset mid-frame: counting resumes from `cap`=0 until the next frame event.

## Test plan
- Reset low, then release → `pos`=128, `pin_out`=1; stays 1 until the first frame event.
- Digital, `fast`=0, `btn_up` held for 3 frames → `pos` 123, 118, 113; loaded `cap` values 128, 123, 118.
- Saturation, with `btn_up` and `btn_down` each held alone:
  - `pos`=3 with `btn_up` → 0.
  - `pos`=252 with `btn_down`, `fast`=1 → 255.
  - Both buttons held → `pos` unchanged.
- Paddle mode, `paddle`=10, `invert`=0 → `pin_out` low after the load and high right after the 10th `hs` rise. With `invert`=1 it goes high after the 245th rise.
- Analog Y with analog[15:8]=8'h80 → `cap`=0 and `pin_out` stays 1. With 8'h7F → 255 lines.
- Acceleration, `ACCEL_FRAMES`=16, `btn_down` held from `pos`=0:
  - Steps of 5 for frames 1..17; frame 18 onward steps of 10.
  - Releasing for one frame restores steps of 5.
- `vs` and `hs` rising in the same cycle with `cap`=5 → `cap` reloads and no decrement occurs.

Source files
------------

// File: rtl/paddle_emu.sv
// -----------------------------------------------------------------------------
// paddle_emu
// Per-player paddle emulation stage for the AY-3-8500 bat inputs. One player's
// control source (digital up/down, analog stick axis or paddle) is turned into
// a line count. The count is loaded on each vertical sync and decremented on
// each horizontal sync. pin_out is high once the count has reached zero. The
// chip reads bat position from the line on which pin_out rises.
//
// Parameters
//   POS_INIT     : digital position after reset (0..255)
//   SPEED_SLOW   : digital step per frame with fast=0 (1..31)
//   SPEED_FAST   : digital step per frame with fast=1 (1..31)
//   ACCEL_FRAMES : consecutive held frames before the step doubles (0 = off)
//
// Ports
//   clk_sys  in  : system clock, all inputs synchronous to it
//   reset    in  : asynchronous active-low reset
//   hs, vs   in  : active-high horizontal / vertical sync
//   mode     in  : 0 digital, 1 analog Y, 2 analog X, 3 paddle
//   invert   in  : XOR the loaded value with 8'hFF
//   fast     in  : select SPEED_FAST for digital steps
//   btn_up   in  : digital up control
//   btn_down in  : digital down control
//   analog   in  : [15:8] Y, [7:0] X, two's complement
//   paddle   in  : unsigned paddle value
//   pos      out : current digital position
//   pin_out  out : high while the line countdown is zero
// -----------------------------------------------------------------------------
module paddle_emu #(
  parameter int unsigned POS_INIT     = 128,
  parameter int unsigned SPEED_SLOW   = 5,
  parameter int unsigned SPEED_FAST   = 8,
  parameter int unsigned ACCEL_FRAMES = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        hs,
  input  logic        vs,
  input  logic [1:0]  mode,
  input  logic        invert,
  input  logic        fast,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic [15:0] analog,
  input  logic [7:0]  paddle,
  output logic [7:0]  pos,
  output logic        pin_out
);

  // Direction state encoding.
  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  // Control source encoding.
  localparam logic [1:0] MODE_DIGITAL  = 2'd0;
  localparam logic [1:0] MODE_ANALOG_Y = 2'd1;
  localparam logic [1:0] MODE_ANALOG_X = 2'd2;
  localparam logic [1:0] MODE_PADDLE   = 2'd3;

  localparam logic [4:0]        HELD_MAX     = 5'd31;
  localparam logic [7:0]        POS_INIT_C   = 8'(POS_INIT);
  localparam logic signed [9:0] SPEED_SLOW_C = $signed(10'(SPEED_SLOW));
  localparam logic signed [9:0] SPEED_FAST_C = $signed(10'(SPEED_FAST));
  localparam bit                ACCEL_EN_C   = (ACCEL_FRAMES != 32'd0);
  // held saturates at 31, so any threshold above that simply never triggers.
  localparam logic [5:0]        ACCEL_THR_C  = (ACCEL_FRAMES > 32'd63) ? 6'd63 : 6'(ACCEL_FRAMES);

  // Step size for this frame. It uses the held count from before the frame's
  // update, so the doubling starts one frame after held reaches the threshold.
  function automatic logic signed [9:0] calc_step(input logic fast_i, input logic [4:0] held_i);
    logic signed [9:0] base;
    base = fast_i ? SPEED_FAST_C : SPEED_SLOW_C;
    if (ACCEL_EN_C && ({1'b0, held_i} >= ACCEL_THR_C)) begin
      calc_step = base <<< 1;
    end else begin
      calc_step = base;
    end
  endfunction

  // Signed move of the position, clamped to 0..255.
  function automatic logic [7:0] sat_move(input logic [7:0] pos_i, input logic signed [9:0] delta_i);
    logic signed [9:0] sum;
    sum = $signed({2'b00, pos_i}) + delta_i;
    if (sum < 10'sd0) begin
      sat_move = 8'd0;
    end else if (sum > 10'sd255) begin
      sat_move = 8'hFF;
    end else begin
      sat_move = sum[7:0];
    end
  endfunction

  logic              hs_d_r;
  logic              vs_d_r;
  logic [7:0]        pos_r;
  logic [7:0]        cap_r;
  logic [4:0]        held_r;
  logic [1:0]        dir_r;

  logic              frame_s;
  logic              line_s;
  logic              digital_s;
  logic [1:0]        dir_next_s;
  logic [4:0]        held_next_s;
  logic signed [9:0] step_s;
  logic [7:0]        pos_next_s;
  logic [7:0]        load_raw_s;
  logic [7:0]        load_s;

  assign frame_s   = vs & ~vs_d_r;
  assign line_s    = hs & ~hs_d_r;
  assign digital_s = (mode == MODE_DIGITAL);

  // Next direction from the buttons; both or neither pressed means idle.
  always_comb begin
    dir_next_s = DIR_IDLE;
    case ({btn_up, btn_down})
      2'b10:   dir_next_s = DIR_UP;
      2'b01:   dir_next_s = DIR_DOWN;
      default: dir_next_s = DIR_IDLE;
    endcase
  end

  // Held-frame counter: cleared on a direction change, saturating while held.
  always_comb begin
    held_next_s = held_r;
    if (dir_next_s != dir_r) begin
      held_next_s = 5'd0;
    end else if (dir_next_s == DIR_IDLE) begin
      held_next_s = held_r;
    end else if (held_r != HELD_MAX) begin
      held_next_s = held_r + 5'd1;
    end else begin
      held_next_s = held_r;
    end
  end

  // Saturating position update for the direction chosen this frame.
  always_comb begin
    step_s     = calc_step(fast, held_r);
    pos_next_s = pos_r;
    case (dir_next_s)
      DIR_UP:   pos_next_s = sat_move(pos_r, -step_s);
      DIR_DOWN: pos_next_s = sat_move(pos_r, step_s);
      default:  pos_next_s = pos_r;
    endcase
  end

  // Value loaded into the countdown. Analog axes are offset to unsigned by
  // flipping the sign bit. Digital mode loads the pre-update position.
  always_comb begin
    load_raw_s = paddle;
    case (mode)
      MODE_DIGITAL:  load_raw_s = pos_r;
      MODE_ANALOG_Y: load_raw_s = {~analog[15], analog[14:8]};
      MODE_ANALOG_X: load_raw_s = {~analog[7], analog[6:0]};
      MODE_PADDLE:   load_raw_s = paddle;
      default:       load_raw_s = paddle;
    endcase
    load_s = load_raw_s ^ {8{invert}};
  end

  // Sync edge detectors.
  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      hs_d_r <= 1'b0;
      vs_d_r <= 1'b0;
    end else begin
      hs_d_r <= hs;
      vs_d_r <= vs;
    end
  end

  // Digital position and direction state, advanced once per frame.
  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      pos_r  <= POS_INIT_C;
      held_r <= 5'd0;
      dir_r  <= DIR_IDLE;
    end else if (frame_s) begin
      if (digital_s) begin
        pos_r  <= pos_next_s;
        held_r <= held_next_s;
        dir_r  <= dir_next_s;
      end else begin
        pos_r  <= pos_r;
        held_r <= 5'd0;
        dir_r  <= DIR_IDLE;
      end
    end else begin
      pos_r  <= pos_r;
      held_r <= held_r;
      dir_r  <= dir_r;
    end
  end

  // Line countdown: a frame load wins over a coincident line decrement.
  always_ff @(posedge clk_sys or negedge reset) begin
    if (!reset) begin
      cap_r <= 8'd0;
    end else if (frame_s) begin
      cap_r <= load_s;
    end else if (line_s && (cap_r != 8'd0)) begin
      cap_r <= cap_r - 8'd1;
    end else begin
      cap_r <= cap_r;
    end
  end

  assign pos     = pos_r;
  assign pin_out = (cap_r == 8'd0);

endmodule
